// File: rtl/vc_input_buffer_pkg.sv
// Shared flit format and link widths for the router input stage.
// Flit type lives in the top bits of each flit; the rest is payload.
package vc_input_buffer_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int VCH_WIDTH     = 4;
  localparam int VCH_WIDTH_NUM = 2;
  localparam int TYPE_MSB      = 31;
  localparam int TYPE_LSB      = 29;
  localparam int PACKET_LEN    = 4;

  typedef enum logic [TYPE_MSB-TYPE_LSB:0] {
    TYPE_NONE     = 3'd0,
    TYPE_HEAD     = 3'd1,
    TYPE_BODY     = 3'd2,
    TYPE_TAIL     = 3'd3,
    TYPE_HEADTAIL = 3'd4
  } flit_type_e;

  function automatic flit_type_e flit_type(input logic [DATA_WIDTH-1:0] flit);
    return flit_type_e'(flit[TYPE_MSB:TYPE_LSB]);
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Circular flit buffer for one virtual channel, DEPTH entries deep.
// A push into a full buffer is dropped unless a pop frees the slot in the same cycle.
module vc_fifo
  import vc_input_buffer_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_wr_en;
  logic                  w_rd_en;

  // Pointers wrap at DEPTH-1, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign w_rd_en = i_pop && !o_empty;
  assign w_wr_en = i_push && (!o_full || w_rd_en);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd_en) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_wr_en && !w_rd_en)      r_count <= r_count + CNT_W'(1);
      else if (!w_wr_en && w_rd_en) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/vc_input_buffer.sv
// Router input stage: four per-VC FIFOs, round-robin head select, credit and packet-lock return.
// Define VCBUF_OVF_CHECK_EN to build the sticky overflow flag on oerr.
module vc_input_buffer
  import vc_input_buffer_pkg::*;
#(
  parameter int ROUTERID = 0,
  parameter int PORTID   = 0,
  parameter int DEPTH    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    idata,
  input  logic                     ivalid,
  input  logic [VCH_WIDTH_NUM-1:0] ivch,
  input  logic                     istall,
  output logic [DATA_WIDTH-1:0]    odata,
  output logic                     ovalid,
  output logic [VCH_WIDTH_NUM-1:0] ovch,
  output logic [VCH_WIDTH-1:0]     oack,
  output logic [VCH_WIDTH-1:0]     olck,
  output logic                     oerr
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  if (ROUTERID < 0 || PORTID < 0 || DEPTH < 2) begin : g_param_chk
    $error("vc_input_buffer: ROUTERID/PORTID must be >= 0 and DEPTH >= 2");
  end

  logic [DATA_WIDTH-1:0]    w_head [VCH_WIDTH];
  logic [CNT_W-1:0]         w_count [VCH_WIDTH];
  logic [VCH_WIDTH-1:0]     w_empty;
  logic [VCH_WIDTH-1:0]     w_full;
  logic [VCH_WIDTH-1:0]     w_push;
  logic [VCH_WIDTH-1:0]     w_pop;
  logic [VCH_WIDTH-1:0]     w_accept;
  logic [VCH_WIDTH-1:0]     w_head_in;
  logic [VCH_WIDTH-1:0]     w_tail_out;
  logic [VCH_WIDTH-1:0]     w_nonzero;
  logic [VCH_WIDTH_NUM-1:0] w_sel;
  logic [VCH_WIDTH_NUM-1:0] w_idx;
  logic                     w_found;
  logic                     w_any;
  logic                     w_deq;

  logic [VCH_WIDTH_NUM-1:0] r_rr;
  logic [VCH_WIDTH-1:0]     r_ack;
  logic [VCH_WIDTH-1:0]     r_lck;

  for (genvar v = 0; v < VCH_WIDTH; v++) begin : g_vc
    assign w_push[v]     = ivalid && (ivch == VCH_WIDTH_NUM'(v));
    assign w_pop[v]      = w_deq && (w_sel == VCH_WIDTH_NUM'(v));
    assign w_accept[v]   = w_push[v] && (!w_full[v] || w_pop[v]);
    assign w_head_in[v]  = w_accept[v] && (flit_type(idata) == TYPE_HEAD);
    assign w_tail_out[v] = w_pop[v] && (flit_type(odata) == TYPE_TAIL);
    assign w_nonzero[v]  = (w_count[v] != '0);

    vc_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push[v]),
      .i_pop   (w_pop[v]),
      .i_data  (idata),
      .o_head  (w_head[v]),
      .o_count (w_count[v]),
      .o_empty (w_empty[v]),
      .o_full  (w_full[v])
    );
  end

  // First non-empty VC at or after the round-robin pointer owns the output.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_rr;
    w_idx   = r_rr;
    for (int i = 0; i < VCH_WIDTH; i++) begin
      w_idx = r_rr + VCH_WIDTH_NUM'(i);
      if (!w_found && !w_empty[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_any  = |w_nonzero;
  assign w_deq  = w_any && !istall;
  assign ovalid = w_any;
  assign odata  = w_any ? w_head[w_sel] : '0;
  assign ovch   = w_any ? w_sel : '0;
  assign oack   = r_ack;
  assign olck   = r_lck;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr  <= '0;
      r_ack <= '0;
      r_lck <= '0;
    end else begin
      r_ack <= w_pop;
      if (w_deq) r_rr <= w_sel + VCH_WIDTH_NUM'(1);
      // A new head on the same VC outranks the tail leaving it.
      for (int v = 0; v < VCH_WIDTH; v++) begin
        if (w_head_in[v])       r_lck[v] <= 1'b1;
        else if (w_tail_out[v]) r_lck[v] <= 1'b0;
      end
    end
  end

`ifdef VCBUF_OVF_CHECK_EN
  logic r_err;
  logic w_drop;

  assign w_drop = |(w_push & ~w_accept);

  always_ff @(posedge clk) begin
    if (!reset)      r_err <= 1'b0;
    else if (w_drop) r_err <= 1'b1;
  end

  assign oerr = r_err;
`else
  assign oerr = 1'b0;
`endif

endmodule
